// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope placed between the convolution filter
// and the DAC. The envelope FSM steps once per sample-clock enable. Each
// captured sample is scaled about midscale by the envelope gain. The result
// reaches the DAC two clocks after the enable, with a one-cycle valid strobe.
// Optional build macro ADSR_VELOCITY_EN: scales the gain by the note velocity
// that was latched when the note started.
module adsr_envelope #(
   parameter logic [15:0] ATTACK_STEP   = 16'h0100,
   parameter logic [15:0] DECAY_STEP    = 16'h0040,
   parameter logic [15:0] SUSTAIN_LEVEL = 16'hA000,
   parameter logic [15:0] RELEASE_STEP  = 16'h0020
) (
   input  logic        inClk,
   input  logic        inReset,
   input  logic        inSampleReady,
   input  logic [11:0] inSample,
   input  logic        inIsPlaying,
   input  logic [6:0]  inVelocity,
   output logic [11:0] outSample,
   output logic        outSampleValid,
   output logic [2:0]  outStage,
   output logic        outActive
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } stage_t;

   // Adds with a 17-bit intermediate and clamps at full scale.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 17'h0FFFF) ? 16'hFFFF : s[15:0];
   endfunction

   // Subtracts with a 17-bit intermediate. The result is clamped to lim on
   // underflow, and also whenever it reaches or passes lim.
   function automatic logic [15:0] sat_sub16(input logic [15:0] a, input logic [15:0] b,
                                             input logic [15:0] lim);
      logic [16:0] d;
      d = {1'b0, a} - {1'b0, b};
      return (d[16] || (d[15:0] <= lim)) ? lim : d[15:0];
   endfunction

   // Unsigned sample to a signed offset from midscale.
   function automatic logic signed [12:0] centre(input logic [11:0] x);
      logic [12:0] t;
      t = {1'b0, x} - 13'd2048;
      return signed'(t);
   endfunction

   // Floor of the product divided by 2^16, then shifted back to unsigned.
   // The result always lies in 0..4095, so no clamp is needed.
   function automatic logic [11:0] recentre(input logic signed [29:0] p);
      return 12'(p[29:16] + 14'd2048);
   endfunction

   stage_t      state_q, state_d;
   logic [15:0] env_q, env_d;
   logic [15:0] gain;

`ifdef ADSR_VELOCITY_EN
   logic [6:0]  vel_q, vel_d;
   logic [22:0] vprod;
   assign vprod = 23'(env_q) * 23'({1'b0, vel_q} + 8'd1);
   assign gain  = 16'(vprod >> 7);
`else
   logic unused_vel;
   assign unused_vel = ^inVelocity;
   assign gain       = env_q;
`endif

   // Envelope step: the gate check comes first, then the level arithmetic for the current stage.
   always_comb begin
      state_d = state_q;
      env_d   = env_q;
`ifdef ADSR_VELOCITY_EN
      vel_d   = vel_q;
`endif
      if (inSampleReady) begin
         case (state_q)
            ST_IDLE: begin
               if (inIsPlaying) begin
                  state_d = ST_ATTACK;
`ifdef ADSR_VELOCITY_EN
                  vel_d   = inVelocity;
`endif
               end
            end
            ST_ATTACK: begin
               if (!inIsPlaying) begin
                  state_d = ST_RELEASE;
               end else begin
                  env_d = sat_add16(env_q, ATTACK_STEP);
                  if (env_d == 16'hFFFF) state_d = ST_DECAY;
               end
            end
            ST_DECAY: begin
               if (!inIsPlaying) begin
                  state_d = ST_RELEASE;
               end else begin
                  env_d = sat_sub16(env_q, DECAY_STEP, SUSTAIN_LEVEL);
                  if (env_d == SUSTAIN_LEVEL) state_d = ST_SUSTAIN;
               end
            end
            ST_SUSTAIN: begin
               if (!inIsPlaying) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
               if (inIsPlaying) begin
                  state_d = ST_ATTACK;
`ifdef ADSR_VELOCITY_EN
                  vel_d   = inVelocity;
`endif
               end else begin
                  env_d = sat_sub16(env_q, RELEASE_STEP, 16'h0000);
                  if (env_d == 16'h0000) state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   logic signed [12:0] s_p0_q;
   logic               vld_p0_q;
   logic signed [29:0] p_p1_q;
   logic               vld_p1_q;
   logic [11:0]        out_q;
   logic               out_vld_q;

   // Control state: FSM, envelope level, velocity latch, the valid pipeline and the held output.
   always_ff @(posedge inClk) begin
      if (inReset) begin
         state_q   <= ST_IDLE;
         env_q     <= 16'h0000;
`ifdef ADSR_VELOCITY_EN
         vel_q     <= 7'd127;
`endif
         vld_p0_q  <= 1'b0;
         vld_p1_q  <= 1'b0;
         out_vld_q <= 1'b0;
         out_q     <= 12'd2048;
      end else begin
         state_q   <= state_d;
         env_q     <= env_d;
`ifdef ADSR_VELOCITY_EN
         vel_q     <= vel_d;
`endif
         vld_p0_q  <= inSampleReady;
         vld_p1_q  <= vld_p0_q;
         out_vld_q <= vld_p1_q;
         if (vld_p1_q) out_q <= recentre(p_p1_q);
      end
   end

   // Data pipeline: p0 captures the centred sample, p1 multiplies it by the updated gain.
   always_ff @(posedge inClk) begin
      if (inSampleReady) s_p0_q <= centre(inSample);
      if (vld_p0_q)      p_p1_q <= 30'(s_p0_q) * 30'($signed({1'b0, gain}));
   end

   assign outSample      = out_q;
   assign outSampleValid = out_vld_q;
   assign outStage       = state_q;
   assign outActive      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;

   localparam logic [15:0] A_STEP = 16'h4000;
   localparam logic [15:0] D_STEP = 16'h1000;
   localparam logic [15:0] SUS    = 16'hC000;
   localparam logic [15:0] R_STEP = 16'h6000;

   logic        inClk = 1'b0;
   logic        inReset = 1'b0;
   logic        inSampleReady = 1'b0;
   logic [11:0] inSample = 12'd2048;
   logic        inIsPlaying = 1'b0;
   logic [6:0]  inVelocity = 7'd127;
   logic [11:0] outSample;
   logic        outSampleValid;
   logic [2:0]  outStage;
   logic        outActive;

   adsr_envelope #(
      .ATTACK_STEP(A_STEP), .DECAY_STEP(D_STEP),
      .SUSTAIN_LEVEL(SUS), .RELEASE_STEP(R_STEP)
   ) dut (
      .inClk(inClk), .inReset(inReset), .inSampleReady(inSampleReady),
      .inSample(inSample), .inIsPlaying(inIsPlaying), .inVelocity(inVelocity),
      .outSample(outSample), .outSampleValid(outSampleValid),
      .outStage(outStage), .outActive(outActive)
   );

   always #5 inClk = ~inClk;

   int checks = 0;
   int failures = 0;

   // Reference model: stage number, envelope level and latched velocity as plain integers.
   int m_stage = 0;
   int m_env = 0;
   int m_vel = 127;

   function automatic int exp_out(input int smp);
      longint s, g, p;
      s = longint'(smp) - 2048;
`ifdef ADSR_VELOCITY_EN
      g = (longint'(m_env) * longint'(m_vel + 1)) >> 7;
`else
      g = m_env;
`endif
      p = s * g;
      return 2048 + int'(p >>> 16);
   endfunction

   task automatic model_step(input bit g, input int v);
      case (m_stage)
         0: if (g) begin m_stage = 1; m_vel = v; end
         1, 2, 3: begin
            if (!g) m_stage = 4;
            else if (m_stage == 1) begin
               m_env = m_env + int'(A_STEP);
               if (m_env >= 65535) begin m_env = 65535; m_stage = 2; end
            end else if (m_stage == 2) begin
               m_env = m_env - int'(D_STEP);
               if (m_env <= int'(SUS)) begin m_env = int'(SUS); m_stage = 3; end
            end
         end
         default: begin
            if (g) begin m_stage = 1; m_vel = v; end
            else begin
               m_env = m_env - int'(R_STEP);
               if (m_env <= 0) begin m_env = 0; m_stage = 0; end
            end
         end
      endcase
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge inClk);
      #1;
   endtask

   task automatic pulse_ce(input int smp, input bit g, input int v);
      inSample = 12'(smp);
      inIsPlaying = g;
      inVelocity = 7'(v);
      inSampleReady = 1'b1;
      @(posedge inClk);
      #1;
      inSampleReady = 1'b0;
      model_step(g, v);
   endtask

   task automatic apply_reset();
      inReset = 1'b1;
      inSampleReady = 1'b1;
      inIsPlaying = 1'b1;
      repeat (2) @(posedge inClk);
      #1;
      inReset = 1'b0;
      inSampleReady = 1'b0;
      inIsPlaying = 1'b0;
      m_stage = 0; m_env = 0; m_vel = 127;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (outSample !== 12'd2048) begin failures++; $display("FAIL reset_sample got=%0d want=2048", outSample); end
      checks++; if (outSampleValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", outSampleValid); end
      checks++; if (outStage !== 3'd0) begin failures++; $display("FAIL reset_stage got=%0d want=0", outStage); end
      checks++; if (outActive !== 1'b0) begin failures++; $display("FAIL reset_active got=%b want=0", outActive); end
   endtask

   task automatic test_idle();
      for (int k = 0; k < 3; k++) begin
         pulse_ce(4000, 1'b0, 127);
         checks++; if (outStage !== 3'd0) begin failures++; $display("FAIL idle_stage got=%0d want=0", outStage); end
         wait_cyc(1);
         checks++; if (outSampleValid !== 1'b0) begin failures++; $display("FAIL idle_early_valid got=%b want=0", outSampleValid); end
         wait_cyc(1);
         checks++; if (outSampleValid !== 1'b1) begin failures++; $display("FAIL idle_valid got=%b want=1", outSampleValid); end
         checks++; if (outSample !== 12'd2048) begin failures++; $display("FAIL idle_sample got=%0d want=2048", outSample); end
         wait_cyc(1);
         checks++; if (outSampleValid !== 1'b0) begin failures++; $display("FAIL idle_strobe_len got=%b want=0", outSampleValid); end
      end
   endtask

   task automatic test_attack_decay();
      int env_tab[9] = '{0, 'h4000, 'h8000, 'hC000, 'hFFFF, 'hEFFF, 'hDFFF, 'hCFFF, 'hC000};
      int st_tab[9]  = '{1, 1, 1, 1, 2, 2, 2, 2, 3};
      int want;
      for (int k = 0; k < 9; k++) begin
         pulse_ce(4095, 1'b1, 127);
         checks++; if (outStage !== 3'(st_tab[k])) begin failures++; $display("FAIL ad_stage[%0d] got=%0d want=%0d", k, outStage, st_tab[k]); end
         checks++; if (outActive !== 1'b1) begin failures++; $display("FAIL ad_active[%0d] got=%b want=1", k, outActive); end
         wait_cyc(2);
         want = 2048 + ((2047 * env_tab[k]) >>> 16);
         checks++; if (outSample !== 12'(want) || outSampleValid !== 1'b1) begin
            failures++; $display("FAIL ad_sample[%0d] got=%0d/v%b want=%0d/v1", k, outSample, outSampleValid, want);
         end
      end
   endtask

   task automatic test_sustain_output();
      pulse_ce(4095, 1'b1, 127);
      wait_cyc(2);
      checks++; if (outSample !== 12'd3583) begin failures++; $display("FAIL sus_max got=%0d want=3583", outSample); end
      pulse_ce(0, 1'b1, 127);
      wait_cyc(2);
      checks++; if (outSample !== 12'd512) begin failures++; $display("FAIL sus_min got=%0d want=512", outSample); end
      checks++; if (outStage !== 3'd3) begin failures++; $display("FAIL sus_stage got=%0d want=3", outStage); end
   endtask

   task automatic test_release();
      int out_tab[3] = '{3583, 2815, 2048};
      int st_tab[3]  = '{4, 4, 0};
      for (int k = 0; k < 3; k++) begin
         pulse_ce(4095, 1'b0, 127);
         checks++; if (outStage !== 3'(st_tab[k])) begin failures++; $display("FAIL rel_stage[%0d] got=%0d want=%0d", k, outStage, st_tab[k]); end
         checks++; if (outActive !== (st_tab[k] != 0)) begin failures++; $display("FAIL rel_active[%0d] got=%b", k, outActive); end
         wait_cyc(2);
         checks++; if (outSample !== 12'(out_tab[k])) begin failures++; $display("FAIL rel_sample[%0d] got=%0d want=%0d", k, outSample, out_tab[k]); end
      end
   endtask

   task automatic test_retrigger();
      for (int k = 0; k < 9; k++) pulse_ce(2048, 1'b1, 127);
      checks++; if (outStage !== 3'd3) begin failures++; $display("FAIL retrig_sustain got=%0d want=3", outStage); end
      pulse_ce(2048, 1'b0, 127);
      pulse_ce(2048, 1'b0, 127);
      pulse_ce(4095, 1'b1, 127);
      checks++; if (outStage !== 3'd1) begin failures++; $display("FAIL retrig_stage got=%0d want=1", outStage); end
      wait_cyc(2);
      checks++; if (outSample !== 12'd2815) begin failures++; $display("FAIL retrig_hold got=%0d want=2815", outSample); end
      pulse_ce(4095, 1'b1, 127);
      wait_cyc(2);
      checks++; if (outSample !== 12'd3327) begin failures++; $display("FAIL retrig_step got=%0d want=3327", outSample); end
      checks++; if (outStage !== 3'(m_stage)) begin failures++; $display("FAIL retrig_stage2 got=%0d want=%0d", outStage, m_stage); end
   endtask

   task automatic test_gate_pulse();
      int want;
      inIsPlaying = 1'b0;
      wait_cyc(2);
      inIsPlaying = 1'b1;
      checks++; if (outStage !== 3'd1) begin failures++; $display("FAIL gp_between got=%0d want=1", outStage); end
      pulse_ce(4095, 1'b1, 127);
      want = exp_out(4095);
      checks++; if (outStage !== 3'd1) begin failures++; $display("FAIL gp_stage got=%0d want=1", outStage); end
      wait_cyc(2);
      checks++; if (outSample !== 12'(want) || want != 3839) begin failures++; $display("FAIL gp_sample got=%0d want=3839", outSample); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      pulse_ce(4095, 1'b1, 127);
      pulse_ce(4095, 1'b1, 127);
      inReset = 1'b1;
      inSampleReady = 1'b1;
      inIsPlaying = 1'b1;
      wait_cyc(1);
      checks++; if (outSampleValid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b want=0", outSampleValid); end
      checks++; if (outSample !== 12'd2048) begin failures++; $display("FAIL rmid_sample got=%0d want=2048", outSample); end
      checks++; if (outStage !== 3'd0) begin failures++; $display("FAIL rmid_stage got=%0d want=0", outStage); end
      inReset = 1'b0;
      inSampleReady = 1'b0;
      inIsPlaying = 1'b0;
      m_stage = 0; m_env = 0; m_vel = 127;
      for (int k = 0; k < 2; k++) begin
         wait_cyc(1);
         checks++; if (outSampleValid !== 1'b0 || outSample !== 12'd2048) begin
            failures++; $display("FAIL rmid_drop[%0d] got=%0d/v%b want=2048/v0", k, outSample, outSampleValid);
         end
      end
   endtask

`ifdef ADSR_VELOCITY_EN
   task automatic test_velocity();
      apply_reset();
      pulse_ce(4095, 1'b1, 63);
      for (int k = 0; k < 4; k++) pulse_ce(4095, 1'b1, 0);
      checks++; if (outStage !== 3'd2) begin failures++; $display("FAIL vel_stage got=%0d want=2", outStage); end
      wait_cyc(2);
      checks++; if (outSample !== 12'd3071) begin failures++; $display("FAIL vel_gain got=%0d want=3071", outSample); end
   endtask
`endif

   task automatic test_back_to_back();
      int exp_q[$];
      int smp, want;
      bit exp_v;
      for (int i = 0; i < 34; i++) begin
         smp = $urandom_range(0, 4095);
         inSample = 12'(smp);
         inIsPlaying = (i < 20);
         inSampleReady = (i < 32);
         @(posedge inClk);
         #1;
         if (i < 32) begin
            model_step(i < 20, 127);
            exp_q.push_back(exp_out(smp));
         end
         inSampleReady = 1'b0;
         exp_v = (i >= 2);
         checks++; if (outSampleValid !== exp_v) begin failures++; $display("FAIL b2b_valid[%0d] got=%b want=%b", i, outSampleValid, exp_v); end
         if (outSampleValid === 1'b1 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++; if (outSample !== 12'(want)) begin failures++; $display("FAIL b2b_sample[%0d] got=%0d want=%0d", i, outSample, want); end
         end
         checks++; if (outStage !== 3'(m_stage)) begin failures++; $display("FAIL b2b_stage[%0d] got=%0d want=%0d", i, outStage, m_stage); end
      end
   endtask

   task automatic test_random();
      int exp_q[$];
      int smp, vel, want;
      bit g, ce, ce1, ce2;
      g = 1'b0; ce1 = 1'b0; ce2 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         ce  = (i < 398) && ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) g = ~g;
         smp = $urandom_range(0, 4095);
         vel = $urandom_range(0, 127);
         inSample = 12'(smp);
         inIsPlaying = g;
         inVelocity = 7'(vel);
         inSampleReady = ce;
         @(posedge inClk);
         #1;
         if (ce) begin
            model_step(g, vel);
            exp_q.push_back(exp_out(smp));
         end
         inSampleReady = 1'b0;
         checks++; if (outSampleValid !== ce2) begin failures++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, outSampleValid, ce2); end
         if (outSampleValid === 1'b1 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++; if (outSample !== 12'(want)) begin failures++; $display("FAIL rnd_sample[%0d] got=%0d want=%0d", i, outSample, want); end
         end
         checks++; if (outStage !== 3'(m_stage) || outActive !== (m_stage != 0)) begin
            failures++; $display("FAIL rnd_stage[%0d] got=%0d/%b want=%0d", i, outStage, outActive, m_stage);
         end
         ce2 = ce1;
         ce1 = ce;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      wait_cyc(1);
      test_reset();
      test_idle();
      test_attack_decay();
      test_sustain_output();
      test_release();
      test_retrigger();
      test_gate_pulse();
      test_reset_mid();
`ifdef ADSR_VELOCITY_EN
      test_velocity();
`endif
      apply_reset();
      test_back_to_back();
      apply_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
